// File: rtl/sram_1w1r_pkg.sv
// sram_1w1r_pkg: shared state type, byte-lane merge and parameter legality for the 1w1r SRAM family
package sram_1w1r_pkg;
  localparam int MAX_DW = 256;
  typedef enum logic {INIT, READY} state_t;
  function automatic logic [MAX_DW-1:0] merge_bytes(input logic [MAX_DW-1:0] old_w, input logic [MAX_DW-1:0] new_w, input logic [MAX_DW/8-1:0] mask);
    logic [MAX_DW-1:0] r;
    for (int i = 0; i < MAX_DW/8; i++) r[8*i+:8] = mask[i] ? new_w[8*i+:8] : old_w[8*i+:8];
    return r;
  endfunction
  function automatic bit params_ok(input int dw, input int rl);
    return dw > 0 && dw % 8 == 0 && dw <= MAX_DW && (rl == 1 || rl == 2);
  endfunction
endpackage

// File: rtl/sram_1w1r_array.sv
// sram_1w1r_array: behavioural storage with byte-masked synchronous write and synchronous read
module sram_1w1r_array import sram_1w1r_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7,
  parameter int WMASK_WIDTH = DATA_WIDTH/8
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [ADDR_WIDTH-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0]  wdata,
  input  logic [WMASK_WIDTH-1:0] wmask,
  input  logic                   re,
  input  logic [ADDR_WIDTH-1:0]  raddr,
  output logic [DATA_WIDTH-1:0]  rdata
);
  logic [DATA_WIDTH-1:0] mem [1<<ADDR_WIDTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= DATA_WIDTH'(merge_bytes(MAX_DW'(mem[waddr]), MAX_DW'(wdata), (MAX_DW/8)'(wmask)));
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/sram_1w1r_masked_bypass.sv
// sram_1w1r_masked_bypass: 1w1r SRAM model with byte masks, init clear, write-first bypass and 1/2-cycle read latency
module sram_1w1r_masked_bypass import sram_1w1r_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7,
  parameter int WMASK_WIDTH = DATA_WIDTH/8,
  parameter int READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  parameter int VERBOSE = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   init_done,
  input  logic                   csb0,
  input  logic [ADDR_WIDTH-1:0]  addr0,
  input  logic [DATA_WIDTH-1:0]  din0,
  input  logic [WMASK_WIDTH-1:0] wmask0,
  input  logic                   csb1,
  input  logic [ADDR_WIDTH-1:0]  addr1,
  output logic [DATA_WIDTH-1:0]  dout1,
  output logic                   dout1_valid,
  output logic                   collision1,
  output logic                   drop
);
  if (!params_ok(DATA_WIDTH, READ_LATENCY)) begin : g_bad_params
    $error("sram_1w1r_masked_bypass: DATA_WIDTH must be a multiple of 8 (<=256) and READ_LATENCY 1 or 2");
  end
  state_t state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt;
  logic ready, x_in, wr_acc, rd_acc, coll;
  logic [DATA_WIDTH-1:0] rdata, s1_wd, s1_word;
  logic [WMASK_WIDTH-1:0] s1_wm;
  logic s1_v, s1_c, s1_x;
  logic o_v, o_c;
  logic [DATA_WIDTH-1:0] o_d;
  assign ready = state == READY;
  assign init_done = ready;
  assign x_in = $isunknown({csb0, csb1, addr0, addr1});
  assign wr_acc = ready && !csb0;
  assign rd_acc = ready && (csb1 !== 1'b1);
  assign coll = wr_acc && rd_acc && addr0 == addr1;
  always_comb state_nxt = (state == INIT && cnt == '1) ? READY : state;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
      cnt <= '0;
      drop <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= ready ? cnt : cnt + 1'b1;
      drop <= !ready && (!csb0 || !csb1);
    end
  end
  sram_1w1r_array #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .WMASK_WIDTH(WMASK_WIDTH)) u_array (
    .clk(clk),
    .we(!ready || wr_acc),
    .waddr(ready ? addr0 : cnt),
    .wdata(ready ? din0 : INIT_VALUE),
    .wmask(ready ? wmask0 : '1),
    .re(rd_acc),
    .raddr(addr1),
    .rdata(rdata)
  );
  // Stage 1 keeps the colliding write so the pre-write array word can be patched write-first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v <= 1'b0;
      s1_c <= 1'b0;
      s1_x <= 1'b0;
      s1_wd <= '0;
      s1_wm <= '0;
    end else begin
      s1_v <= rd_acc;
      s1_c <= coll;
      s1_x <= ready && x_in;
      s1_wd <= din0;
      s1_wm <= wmask0;
    end
  end
  always_comb s1_word = s1_x ? 'x : s1_c ? DATA_WIDTH'(merge_bytes(MAX_DW'(rdata), MAX_DW'(s1_wd), (MAX_DW/8)'(s1_wm))) : rdata;
  if (READ_LATENCY == 2) begin : g_lat2
    logic s2_v, s2_c;
    logic [DATA_WIDTH-1:0] s2_d;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s2_v <= 1'b0;
        s2_c <= 1'b0;
        s2_d <= '0;
      end else begin
        s2_v <= s1_v;
        s2_c <= s1_c;
        s2_d <= s1_word;
      end
    end
    assign o_v = s2_v;
    assign o_c = s2_c;
    assign o_d = s2_d;
  end else begin : g_lat1
    assign o_v = s1_v;
    assign o_c = s1_c;
    assign o_d = s1_word;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout1 <= '0;
      dout1_valid <= 1'b0;
      collision1 <= 1'b0;
    end else begin
      dout1_valid <= o_v;
      collision1 <= o_v && o_c;
      if (o_v) dout1 <= o_d;
    end
  end
`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (coll) $display("%m warning: write/read collision at addr 0x%0h", addr0);
    if (ready && x_in) $display("%m warning: X on csb/addr, read data corrupted");
    if (VERBOSE != 0 && wr_acc) $display("%m write addr 0x%0h data 0x%0h mask 0x%0h", addr0, din0, wmask0);
    if (VERBOSE != 0 && rd_acc) $display("%m read addr 0x%0h", addr1);
  end
`endif
endmodule

// File: tb/tb_sram_1w1r_masked_bypass.sv
// tb_sram_1w1r_masked_bypass: directed checks of init, masking, bypass, latency and reset behaviour
module tb_sram_1w1r_masked_bypass;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic csb0 = 1'b1, csb1 = 1'b1;
  logic [6:0] addr0 = '0, addr1 = '0;
  logic [31:0] din0 = '0;
  logic [3:0] wmask0 = '0;
  logic d1_init_done, d1_valid, d1_coll, d1_drop;
  logic d2_init_done, d2_valid, d2_coll, d2_drop;
  logic [31:0] d1_dout, d2_dout;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  sram_1w1r_masked_bypass #(.READ_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .init_done(d1_init_done), .csb0(csb0), .addr0(addr0), .din0(din0), .wmask0(wmask0),
    .csb1(csb1), .addr1(addr1), .dout1(d1_dout), .dout1_valid(d1_valid), .collision1(d1_coll), .drop(d1_drop)
  );
  sram_1w1r_masked_bypass #(.READ_LATENCY(2)) u_dut2 (
    .clk(clk), .rst(rst), .init_done(d2_init_done), .csb0(csb0), .addr0(addr0), .din0(din0), .wmask0(wmask0),
    .csb1(csb1), .addr1(addr1), .dout1(d2_dout), .dout1_valid(d2_valid), .collision1(d2_coll), .drop(d2_drop)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [6:0] a, input logic [31:0] d, input logic [3:0] m);
    csb0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
    tick();
    csb0 = 1'b1;
  endtask
  task automatic rd(input logic [6:0] a);
    csb1 = 1'b0; addr1 = a;
    tick();
    csb1 = 1'b1;
  endtask
  task automatic wait_init(output int n);
    n = 0;
    while (!d1_init_done && n < 400) begin
      tick();
      n++;
    end
  endtask
  task automatic test_reset;
    int n;
    rst = 1'b1;
    tick(); tick();
    n_chk++; if ({d1_init_done, d1_valid, d1_coll, d1_drop} !== 4'b0) begin n_fail++; $display("FAIL reset_flags got %b exp 0000", {d1_init_done, d1_valid, d1_coll, d1_drop}); end
    n_chk++; if (d1_dout !== 32'h0) begin n_fail++; $display("FAIL reset_dout got %h exp 00000000", d1_dout); end
    rst = 1'b0;
    wait_init(n);
    n_chk++; if (n !== 128) begin n_fail++; $display("FAIL init_cycles got %0d exp 128", n); end
    n_chk++; if (d2_init_done !== 1'b1) begin n_fail++; $display("FAIL init_done_lat2 got %b exp 1", d2_init_done); end
  endtask
  task automatic test_idle_reads;
    logic [6:0] addrs [3] = '{7'd0, 7'd63, 7'd127};
    foreach (addrs[k]) begin
      rd(addrs[k]);
      n_chk++; if (d1_valid !== 1'b0) begin n_fail++; $display("FAIL idle_early_valid addr %0d got %b exp 0", addrs[k], d1_valid); end
      tick();
      n_chk++; if ({d1_valid, d1_coll, d1_dout} !== {2'b10, 32'h0}) begin n_fail++; $display("FAIL idle_read addr %0d got v=%b c=%b d=%h exp v=1 c=0 d=00000000", addrs[k], d1_valid, d1_coll, d1_dout); end
    end
  endtask
  task automatic test_masked_write;
    wr(7'd5, 32'hDEADBEEF, 4'b1111);
    wr(7'd5, 32'h11223344, 4'b0101);
    rd(7'd5);
    tick();
    n_chk++; if ({d1_valid, d1_dout} !== {1'b1, 32'hDE22BE44}) begin n_fail++; $display("FAIL masked_write got v=%b d=%h exp v=1 d=DE22BE44", d1_valid, d1_dout); end
    wr(7'd6, 32'hCAFEBABE, 4'b1111);
    wr(7'd6, 32'hFFFFFFFF, 4'b0000);
    rd(7'd6);
    tick();
    n_chk++; if ({d1_valid, d1_dout} !== {1'b1, 32'hCAFEBABE}) begin n_fail++; $display("FAIL zero_mask got v=%b d=%h exp v=1 d=CAFEBABE", d1_valid, d1_dout); end
  endtask
  task automatic test_collision;
    wr(7'd9, 32'h01020304, 4'b1111);
    csb0 = 1'b0; addr0 = 7'd9; din0 = 32'hAABBCCDD; wmask0 = 4'b1100;
    csb1 = 1'b0; addr1 = 7'd9;
    tick();
    csb0 = 1'b1; csb1 = 1'b1;
    tick();
    n_chk++; if ({d1_valid, d1_coll, d1_dout} !== {2'b11, 32'hAABB0304}) begin n_fail++; $display("FAIL collision_lat1 got v=%b c=%b d=%h exp v=1 c=1 d=AABB0304", d1_valid, d1_coll, d1_dout); end
    tick();
    n_chk++; if ({d2_valid, d2_coll, d2_dout} !== {2'b11, 32'hAABB0304}) begin n_fail++; $display("FAIL collision_lat2 got v=%b c=%b d=%h exp v=1 c=1 d=AABB0304", d2_valid, d2_coll, d2_dout); end
    n_chk++; if ({d1_valid, d1_coll, d1_dout} !== {2'b00, 32'hAABB0304}) begin n_fail++; $display("FAIL collision_hold got v=%b c=%b d=%h exp v=0 c=0 d=AABB0304", d1_valid, d1_coll, d1_dout); end
    rd(7'd9);
    tick();
    n_chk++; if ({d1_valid, d1_coll, d1_dout} !== {2'b10, 32'hAABB0304}) begin n_fail++; $display("FAIL collision_after got v=%b c=%b d=%h exp v=1 c=0 d=AABB0304", d1_valid, d1_coll, d1_dout); end
  endtask
  task automatic test_read_then_write;
    rd(7'd5);
    wr(7'd5, 32'hCAFEF00D, 4'b1111);
    n_chk++; if ({d1_valid, d1_coll, d1_dout} !== {2'b10, 32'hDE22BE44}) begin n_fail++; $display("FAIL read_old got v=%b c=%b d=%h exp v=1 c=0 d=DE22BE44", d1_valid, d1_coll, d1_dout); end
    rd(7'd5);
    tick();
    n_chk++; if (d1_dout !== 32'hCAFEF00D) begin n_fail++; $display("FAIL read_new got %h exp CAFEF00D", d1_dout); end
  endtask
  task automatic test_back_to_back;
    logic [31:0] exp2 [6] = '{32'h0, 32'h0, 32'h1, 32'h2, 32'h3, 32'h3};
    logic        v2   [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    wr(7'd1, 32'h1, 4'b1111);
    wr(7'd2, 32'h2, 4'b1111);
    wr(7'd3, 32'h3, 4'b1111);
    csb1 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      addr1 = 7'(k + 1);
      if (k >= 3) csb1 = 1'b1;
      tick();
      n_chk++;
      if (d2_valid !== v2[k] || (v2[k] && d2_dout !== exp2[k])) begin n_fail++; $display("FAIL b2b_lat2 step %0d got v=%b d=%h exp v=%b d=%h", k, d2_valid, d2_dout, v2[k], exp2[k]); end
      if (k >= 1 && k <= 3) begin
        n_chk++; if ({d1_valid, d1_dout} !== {1'b1, 32'(k)}) begin n_fail++; $display("FAIL b2b_lat1 step %0d got v=%b d=%h exp v=1 d=%h", k, d1_valid, d1_dout, 32'(k)); end
      end
    end
    n_chk++; if (d2_dout !== 32'h3) begin n_fail++; $display("FAIL b2b_hold got %h exp 00000003", d2_dout); end
  endtask
  task automatic test_init_drop;
    int n;
    wr(7'd20, 32'h55555555, 4'b1111);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (9) tick();
    csb0 = 1'b0; addr0 = 7'd20; din0 = 32'hFFFFFFFF; wmask0 = 4'b1111;
    csb1 = 1'b0; addr1 = 7'd20;
    tick();
    csb0 = 1'b1; csb1 = 1'b1;
    n_chk++; if ({d1_drop, d1_valid} !== 2'b10) begin n_fail++; $display("FAIL drop_pulse got drop=%b v=%b exp drop=1 v=0", d1_drop, d1_valid); end
    tick();
    n_chk++; if ({d1_drop, d1_valid} !== 2'b00) begin n_fail++; $display("FAIL drop_end got drop=%b v=%b exp drop=0 v=0", d1_drop, d1_valid); end
    wait_init(n);
    n_chk++; if (n !== 117) begin n_fail++; $display("FAIL init_remaining got %0d exp 117", n); end
    rd(7'd20);
    tick();
    n_chk++; if ({d1_valid, d1_dout} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL init_cleared got v=%b d=%h exp v=1 d=00000000", d1_valid, d1_dout); end
  endtask
  task automatic test_rst_mid_init;
    int n;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (59) tick();
    rst = 1'b1;
    tick();
    n_chk++; if (d1_init_done !== 1'b0) begin n_fail++; $display("FAIL mid_init_done got %b exp 0", d1_init_done); end
    rst = 1'b0;
    wait_init(n);
    n_chk++; if (n !== 128) begin n_fail++; $display("FAIL restart_cycles got %0d exp 128", n); end
  endtask
  task automatic test_rst_inflight;
    int n;
    rd(7'd9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_chk++; if ({d1_valid, d2_valid} !== 2'b00) begin n_fail++; $display("FAIL inflight_valid step %0d got lat1=%b lat2=%b exp 0 0", k, d1_valid, d2_valid); end
      tick();
    end
    wait_init(n);
    n_chk++; if (n !== 125) begin n_fail++; $display("FAIL inflight_init got %0d exp 125", n); end
  endtask
  initial begin
    test_reset();
    test_idle_reads();
    test_masked_write();
    test_collision();
    test_read_then_write();
    test_back_to_back();
    test_init_drop();
    test_rst_mid_init();
    test_rst_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
